// File: rtl/truth_sweep_pkg.sv
// Shared types and constants for the truth-table sweep stage.
package truth_sweep_pkg;

  localparam int unsigned VEC_W   = 4;
  localparam int unsigned NUM_VEC = 16;

  // Minterms {4,8,9,12,13,14} of (X+Y)(X+~Z)(X+~W)(~W+~Z)(Y+~W).
  localparam logic [NUM_VEC-1:0] REF_MASK_0101D = 16'h7310;

  typedef enum logic [1:0] {
    StIdle,
    StDrive,
    StSample,
    StDone
  } sweep_state_e;

  // Number of set bits; 5 bits wide so that 16 is representable.
  function automatic logic [4:0] popcount16(input logic [NUM_VEC-1:0] v);
    logic [4:0] c;
    c = '0;
    for (int i = 0; i < int'(NUM_VEC); i++) begin
      c = c + {4'b0000, v[i]};
    end
    return c;
  endfunction

endpackage

// File: rtl/sweep_index_counter.sv
// Vector index and per-vector settle counter, steered by the sweep FSM.
module sweep_index_counter
  import truth_sweep_pkg::*;
#(
  parameter int unsigned SETTLE = 1
) (
  input  logic             clk,
  input  logic             rstn,
  input  logic             clear,
  input  logic             advance,
  input  logic             count,
  output logic [VEC_W-1:0] idx,
  output logic             settle_done,
  output logic             last_vec
);

  localparam logic [3:0]       SettleLast = 4'(SETTLE - 1);
  localparam logic [VEC_W-1:0] IdxLast    = VEC_W'(NUM_VEC - 1);

  logic [VEC_W-1:0] idx_q;
  logic [3:0]       settle_q;

  // Clear restarts the sweep, advance steps to the next vector, count ticks the settle time.
  always_ff @(posedge clk) begin
    if (!rstn) begin
      idx_q    <= '0;
      settle_q <= '0;
    end else if (clear) begin
      idx_q    <= '0;
      settle_q <= '0;
    end else if (advance) begin
      idx_q    <= idx_q + 1'b1;
      settle_q <= '0;
    end else if (count) begin
      settle_q <= settle_q + 1'b1;
    end
  end

  assign idx         = idx_q;
  assign settle_done = (settle_q == SettleLast);
  assign last_vec    = (idx_q == IdxLast);

endmodule

// File: rtl/truth_table_sweeper.sv
// Clocked exhaustive sweep of a 4-input function: drives each vector, captures s_in,
// and compares the assembled truth vector against an expected mask.
module truth_table_sweeper
  import truth_sweep_pkg::*;
#(
  parameter int unsigned        SETTLE   = 1,
  parameter logic [NUM_VEC-1:0] EXPECTED = REF_MASK_0101D
) (
  input  logic                clk,
  input  logic                rstn,
  input  logic                start,
  input  logic                s_in,
  output logic                X,
  output logic                Y,
  output logic                W,
  output logic                Z,
  output logic                busy,
  output logic                done,
  output logic [NUM_VEC-1:0]  truth,
  output logic                match,
  output logic [4:0]          err_count
);

  sweep_state_e       state_q;
  logic               busy_q;
  logic               done_q;
  logic [NUM_VEC-1:0] truth_q;
  logic               match_q;
  logic [4:0]         err_q;

  logic [VEC_W-1:0]   idx;
  logic               settle_done;
  logic               last_vec;
  logic               cnt_clear;
  logic               cnt_advance;
  logic               cnt_count;
  logic [NUM_VEC-1:0] truth_d;

  sweep_index_counter #(
    .SETTLE (SETTLE)
  ) u_counter (
    .clk         (clk),
    .rstn        (rstn),
    .clear       (cnt_clear),
    .advance     (cnt_advance),
    .count       (cnt_count),
    .idx         (idx),
    .settle_done (settle_done),
    .last_vec    (last_vec)
  );

  // Counter controls and the truth vector as it will look after this SAMPLE cycle.
  always_comb begin
    cnt_clear      = start && ((state_q == StIdle) || (state_q == StDone));
    cnt_count      = (state_q == StDrive) && !settle_done;
    cnt_advance    = (state_q == StSample) && !last_vec;
    truth_d        = truth_q;
    truth_d[idx]   = s_in;
  end

  // Sweep FSM with registered status and result outputs.
  always_ff @(posedge clk) begin
    if (!rstn) begin
      state_q <= StIdle;
      busy_q  <= 1'b0;
      done_q  <= 1'b0;
      truth_q <= '0;
      match_q <= 1'b0;
      err_q   <= '0;
    end else begin
      unique case (state_q)
        StIdle, StDone: begin
          if (start) begin
            state_q <= StDrive;
            busy_q  <= 1'b1;
            done_q  <= 1'b0;
            truth_q <= '0;
          end
        end
        StDrive: begin
          if (settle_done) begin
            state_q <= StSample;
          end
        end
        StSample: begin
          truth_q <= truth_d;
          if (last_vec) begin
            // Results are taken from truth_d so the final sample is included.
            state_q <= StDone;
            busy_q  <= 1'b0;
            done_q  <= 1'b1;
            match_q <= (truth_d == EXPECTED);
            err_q   <= popcount16(truth_d ^ EXPECTED);
          end else begin
            state_q <= StDrive;
          end
        end
        default: begin
          state_q <= StIdle;
          busy_q  <= 1'b0;
        end
      endcase
    end
  end

  assign {X, Y, W, Z} = idx;
  assign busy         = busy_q;
  assign done         = done_q;
  assign truth        = truth_q;
  assign match        = match_q;
  assign err_count    = err_q;

endmodule

// File: tb/tb_truth_table_sweeper.sv
// Scoreboard bench for truth_table_sweeper: SETTLE=1 and SETTLE=3 instances.
module tb_truth_table_sweeper;

  typedef struct {
    logic [15:0] truth;
    logic        match;
    logic [4:0]  err;
    int          lat;
  } exp_t;

  logic clk = 1'b0;
  always #5 clk = ~clk;

  logic        rstn;
  logic        start1, start3;
  logic        s1, s3;
  logic        x1, y1, w1, z1, busy1, done1, match1;
  logic        x3, y3, w3, z3, busy3, done3, match3;
  logic [15:0] truth1, truth3;
  logic [4:0]  err1, err3;

  int checks = 0;
  int errors = 0;
  int cyc    = 0;
  int ks1    = 0;
  int ks3    = 0;
  int mode   = 0;  // 0 POS function, 1 const 0, 2 const 1, 3 s=Z, 4 s=X
  logic done1_prev = 1'b0;
  logic done3_prev = 1'b0;

  exp_t q1[$];
  exp_t q3[$];

  truth_table_sweeper #(.SETTLE(1), .EXPECTED(16'h7310)) dut1 (
    .clk(clk), .rstn(rstn), .start(start1), .s_in(s1),
    .X(x1), .Y(y1), .W(w1), .Z(z1), .busy(busy1), .done(done1),
    .truth(truth1), .match(match1), .err_count(err1)
  );

  truth_table_sweeper #(.SETTLE(3), .EXPECTED(16'h7310)) dut3 (
    .clk(clk), .rstn(rstn), .start(start3), .s_in(s3),
    .X(x3), .Y(y3), .W(w3), .Z(z3), .busy(busy3), .done(done3),
    .truth(truth3), .match(match3), .err_count(err3)
  );

  function automatic logic fsrc(input int m, input logic x, input logic y,
                                input logic w, input logic z);
    case (m)
      0:       return (x | y) & (x | ~z) & (x | ~w) & (~w | ~z) & (y | ~w);
      1:       return 1'b0;
      2:       return 1'b1;
      3:       return z;
      default: return x;
    endcase
  endfunction

  always_comb s1 = fsrc(mode, x1, y1, w1, z1);
  always_comb s3 = fsrc(mode, x3, y3, w3, z3);

  always @(posedge clk) cyc <= cyc + 1;

  task automatic check(input string nm, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s got %0h want %0h", nm, act, exp);
    end
  endtask

  // Monitor for the SETTLE=1 instance: score each completed sweep.
  always @(negedge clk) begin
    exp_t e;
    if (rstn && done1 && !done1_prev) begin
      if (q1.size() == 0) begin
        checks++;
        errors++;
        $display("FAIL dut1_unexpected_done got done=1 want no result");
      end else begin
        e = q1.pop_front();
        check("dut1_truth", 32'(truth1), 32'(e.truth));
        check("dut1_match", 32'(match1), 32'(e.match));
        check("dut1_err",   32'(err1),   32'(e.err));
        check("dut1_lat",   32'(cyc - ks1), 32'(e.lat));
        check("dut1_busy_at_done", 32'(busy1), 32'd0);
      end
    end
    done1_prev = done1;
  end

  // Monitor for the SETTLE=3 instance: vector order every cycle plus the result.
  always @(negedge clk) begin
    exp_t e;
    logic [3:0] want;
    if (rstn && busy3) begin
      want = 4'((cyc - ks3) / 4);
      check("dut3_vec", 32'({x3, y3, w3, z3}), 32'(want));
    end
    if (rstn && done3 && !done3_prev) begin
      if (q3.size() == 0) begin
        checks++;
        errors++;
        $display("FAIL dut3_unexpected_done got done=1 want no result");
      end else begin
        e = q3.pop_front();
        check("dut3_truth", 32'(truth3), 32'(e.truth));
        check("dut3_match", 32'(match3), 32'(e.match));
        check("dut3_err",   32'(err3),   32'(e.err));
        check("dut3_lat",   32'(cyc - ks3), 32'(e.lat));
      end
    end
    done3_prev = done3;
  end

  task automatic kick1(input logic push, input logic [15:0] t, input logic m,
                       input logic [4:0] e);
    exp_t x;
    @(negedge clk);
    start1 = 1'b1;
    ks1 = cyc + 1;
    if (push) begin
      x.truth = t; x.match = m; x.err = e; x.lat = 32;
      q1.push_back(x);
    end
    @(negedge clk);
    start1 = 1'b0;
  endtask

  task automatic kick3(input logic [15:0] t, input logic m, input logic [4:0] e);
    exp_t x;
    @(negedge clk);
    start3 = 1'b1;
    ks3 = cyc + 1;
    x.truth = t; x.match = m; x.err = e; x.lat = 64;
    q3.push_back(x);
    @(negedge clk);
    start3 = 1'b0;
  endtask

  task automatic wait_done1(input int budget);
    int n = 0;
    while (!done1 && n < budget) begin
      @(negedge clk);
      n++;
    end
    if (!done1) begin
      checks++;
      errors++;
      $display("FAIL dut1_done_timeout got done=0 want done=1");
    end
    @(negedge clk);
  endtask

  task automatic wait_done3(input int budget);
    int n = 0;
    while (!done3 && n < budget) begin
      @(negedge clk);
      n++;
    end
    if (!done3) begin
      checks++;
      errors++;
      $display("FAIL dut3_done_timeout got done=0 want done=1");
    end
    @(negedge clk);
  endtask

  task automatic wait_vec1(input logic [3:0] v, input int budget);
    int n = 0;
    while (!(busy1 && {x1, y1, w1, z1} == v) && n < budget) begin
      @(negedge clk);
      n++;
    end
    if (!(busy1 && {x1, y1, w1, z1} == v)) begin
      checks++;
      errors++;
      $display("FAIL dut1_vec_timeout got %0h want %0h", {x1, y1, w1, z1}, v);
    end
  endtask

  task automatic check_zero1(input string nm);
    check({nm, "_stim"},  32'({x1, y1, w1, z1}), 32'd0);
    check({nm, "_busy"},  32'(busy1),  32'd0);
    check({nm, "_done"},  32'(done1),  32'd0);
    check({nm, "_truth"}, 32'(truth1), 32'd0);
    check({nm, "_match"}, 32'(match1), 32'd0);
    check({nm, "_err"},   32'(err1),   32'd0);
  endtask

  initial begin
    #2000000;
    $display("FAIL watchdog got no finish want finish");
    $fatal(1, "watchdog");
  end

  initial begin
    rstn   = 1'b0;
    start1 = 1'b0;
    start3 = 1'b0;
    mode   = 0;
    repeat (3) @(negedge clk);
    check_zero1("reset");
    rstn = 1'b1;
    @(negedge clk);

    // POS function, then a restart from DONE that must reproduce the result.
    kick1(1'b1, 16'h7310, 1'b1, 5'd0);
    wait_done1(100);
    kick1(1'b1, 16'h7310, 1'b1, 5'd0);
    check("restart_done",  32'(done1),  32'd0);
    check("restart_busy",  32'(busy1),  32'd1);
    check("restart_truth", 32'(truth1), 32'd0);
    check("restart_stim",  32'({x1, y1, w1, z1}), 32'd0);
    wait_done1(100);

    // Constant and single-input sources.
    mode = 1; kick1(1'b1, 16'h0000, 1'b0, 5'd6);  wait_done1(100);
    mode = 2; kick1(1'b1, 16'hFFFF, 1'b0, 5'd10); wait_done1(100);
    mode = 3; kick1(1'b1, 16'hAAAA, 1'b0, 5'd10); wait_done1(100);
    mode = 4; kick1(1'b1, 16'hFF00, 1'b0, 5'd4);  wait_done1(100);

    // Start pulses mid-sweep are ignored.
    mode = 0;
    kick1(1'b1, 16'h7310, 1'b1, 5'd0);
    wait_vec1(4'd2, 100);
    start1 = 1'b1; @(negedge clk); start1 = 1'b0;
    wait_vec1(4'd9, 100);
    start1 = 1'b1; @(negedge clk); start1 = 1'b0;
    wait_done1(100);

    // SETTLE=3: 4 cycles per vector, done after 64.
    kick3(16'h7310, 1'b1, 5'd0);
    wait_done3(200);

    // Reset during vector 7 discards the partial sweep.
    kick1(1'b0, 16'h0000, 1'b0, 5'd0);
    wait_vec1(4'd7, 100);
    rstn = 1'b0;
    @(negedge clk);
    check_zero1("midrst");
    rstn = 1'b1;
    repeat (2) @(negedge clk);
    check("midrst_idle_busy", 32'(busy1), 32'd0);
    kick1(1'b1, 16'h7310, 1'b1, 5'd0);
    wait_done1(100);

    check("q1_empty", 32'(q1.size()), 32'd0);
    check("q3_empty", 32'(q3.size()), 32'd0);
    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule
